multi_debounce: RTL and testbench
=================================

Name: multi_debounce

Overview:
Parametrised multi-channel push-button/switch debouncer.
- Each of N_CH asynchronous inputs passes through a configurable synchroniser chain.
- A per-channel stability counter accepts a new level only after it has held for STABLE_CYCLES clocks.
- Outputs are the debounced level plus single-cycle rise and fall strobes per channel.
- Sits between board I/O pins and control logic (e.g. SPI transaction triggers) in the Cyclone 10 LP design.

Parameters:
- N_CH, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2).
- STABLE_CYCLES, 50000, clocks an input must hold a new level before acceptance (1 ms at 50 MHz; >=1).
- IDLE_LEVEL, 1'b0, debounced output level during and after reset (applies to all channels).

Ports:
- clk, in, 1, system clock; all logic is on its rising edge.
- rst, in, 1, synchronous active-high reset.
- btn_in, in, N_CH, raw asynchronous inputs.
- btn_db, out, N_CH, debounced levels.
- rise_pulse, out, N_CH, one-cycle strobe when btn_db[i] goes 0->1.
- fall_pulse, out, N_CH, one-cycle strobe when btn_db[i] goes 1->0.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No asynchronous reset anywhere.
- While rst=1 at a rising edge:
  - all sync stages <= IDLE_LEVEL
  - btn_db <= {N_CH{IDLE_LEVEL}}
  - counters <= 0
  - rise_pulse = fall_pulse = 0
- Reset mid-count discards all progress. The first post-reset edge behaves as a fresh start.
- Synchroniser: stage0 <= btn_in[i], and stage k <= stage k-1. s[i] denotes the last stage.
- Per channel, each edge with rst=0, evaluated in priority order:
  - s==btn_db: cnt <= 0, no pulse.
  - else if cnt==STABLE_CYCLES-1: btn_db <= s, cnt <= 0. Assert rise_pulse (if s=1) or fall_pulse (if s=0) for exactly this one cycle, coincident with the btn_db change.
  - else: cnt <= cnt+1.
- Latency: btn_in changes before edge E0, so stage0 captures it at E0. s reflects it after edge E0+SYNC_STAGES-1. btn_db changes at edge E0+SYNC_STAGES-1+STABLE_CYCLES, provided the input holds throughout.
- Glitch rejection: any return of s to btn_db before the count completes clears cnt to 0. Pulses shorter than STABLE_CYCLES clocks (after synchronisation) never reach btn_db.
- STABLE_CYCLES=1: btn_db follows s with a one-cycle delay, with no filtering.
- Counter width CNT_W = max(1, clog2(STABLE_CYCLES)). The counter never exceeds STABLE_CYCLES-1, so it does not wrap.
- Channels are fully independent. Simultaneous acceptance on several channels produces simultaneous pulses.
- rise_pulse[i] and fall_pulse[i] are never high together. Each is high for at most 1 cycle per transition.
- All outputs are registered, so there is no combinational path from btn_in.

Decomposition:
- Shared package/header holds:
  - the clog2 constant function
  - default constants: DEF_SYNC_STAGES=2, DEF_STABLE_CYCLES=50000 (parameterised for clock frequency)
- Sub-module debounce_channel: one synchroniser, counter, level register and pulse pair, with parameters SYNC_STAGES, STABLE_CYCLES and IDLE_LEVEL.
- multi_debounce instantiates it N_CH times in a generate loop.

Test Plan (N_CH=4, SYNC_STAGES=2, STABLE_CYCLES=8, IDLE_LEVEL=0 unless stated):
- Reset: hold rst 3 cycles with btn_in=4'hF -> btn_db=0 and pulses=0 during reset. After release with btn_in held, btn_db=4'hF exactly 2-1+8=9 edges after the first non-reset edge. rise_pulse=4'hF for that one cycle.
- Clean press ch0: btn_in[0] 0->1 and held -> btn_db[0]=1 at edge E0+9. rise_pulse[0]=1 for 1 cycle only. Releasing and holding gives fall_pulse[0] with the same latency.
- Bounce ch1: btn_in[1] toggles high 5 cycles, low 1, high 5, low, then stays low -> btn_db[1] never changes and no pulses.
- Bounce then settle ch2: 3 glitches of 2 cycles, then held high -> btn_db[2] rises exactly 9 edges after the final low->high edge. Exactly one rise_pulse.
- Independence: ch0 and ch3 pressed on the same edge, ch1 pressed 3 cycles later -> ch0 and ch3 pulse together, ch1 pulses 3 cycles later. Channel 2 stays static.
- Mid-count reset: press ch0, assert rst after 5 stable cycles -> btn_db[0] stays 0. After release of rst, the full 9-edge latency restarts. Repeat with STABLE_CYCLES=1: btn_db follows the input 1 edge after s.

Source files
------------

// File: rtl/multi_debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// Holds default timing constants and counter-width helpers.
package multi_debounce_pkg;

   localparam int DEF_SYNC_STAGES   = 2;
   // 1 ms at a 50 MHz clock; rescale for other clock rates.
   localparam int DEF_STABLE_CYCLES = 50000;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Counter holds 0..STABLE_CYCLES-1; keep at least one bit.
   function automatic int cnt_width(input int stable);
      int w;
      w = clog2(stable);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/multi_debounce_channel.sv
// One debounce channel: synchroniser, stability counter, level and pulses.
// Ports: clk, rst, btn_in (raw) -> btn_db, rise_pulse, fall_pulse.
module debounce_channel
   import multi_debounce_pkg::*;
#(
   parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter logic IDLE_LEVEL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_db,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int CNT_W = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   s;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
      s      = sync_q[SYNC_STAGES-1];
      cnt_d  = cnt_q;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s == db_q) begin
         // Any return to the accepted level discards progress.
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         db_d   = s;
         cnt_d  = '0;
         rise_d = s;
         fall_d = ~s;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
         cnt_q  <= '0;
         db_q   <= IDLE_LEVEL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign btn_db     = db_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: rtl/multi_debounce.sv
// Multi-channel push-button/switch debouncer, one channel per input bit.
// Ports: clk, rst, btn_in[N_CH] -> btn_db, rise_pulse, fall_pulse [N_CH].
module multi_debounce
   import multi_debounce_pkg::*;
#(
   parameter int   N_CH          = 4,
   parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter logic IDLE_LEVEL    = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_db,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES),
         .IDLE_LEVEL   (IDLE_LEVEL)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .btn_in    (btn_in[i]),
         .btn_db    (btn_db[i]),
         .rise_pulse(rise_pulse[i]),
         .fall_pulse(fall_pulse[i])
      );
   end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed scoreboard bench for multi_debounce (STABLE=8 and STABLE=1).
// Expected pulse events are queued at stimulus time and checked per edge.
module tb_multi_debounce;

   typedef struct {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn = 4'h0;
   logic [3:0] db, rise, fall;

   logic       rst1 = 1'b1;
   logic [3:0] btn1 = 4'h0;
   logic [3:0] db1, rise1, fall1;

   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   logic       ed_rst;
   logic [3:0] exp_db = 4'h0;
   logic [3:0] exp_r, exp_f;
   ev_t        sb[$];

   // Latency from a drive (after negedge of cycle c) to acceptance edge.
   localparam int LAT = 10;

   always #5 clk = ~clk;

   multi_debounce #(
      .N_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(8), .IDLE_LEVEL(1'b0)
   ) u_dut (
      .clk(clk), .rst(rst), .btn_in(btn),
      .btn_db(db), .rise_pulse(rise), .fall_pulse(fall)
   );

   multi_debounce #(
      .N_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(1), .IDLE_LEVEL(1'b0)
   ) u_dut1 (
      .clk(clk), .rst(rst1), .btn_in(btn1),
      .btn_db(db1), .rise_pulse(rise1), .fall_pulse(fall1)
   );

   task automatic push(input logic [3:0] r, input logic [3:0] f);
      ev_t e;
      e.cyc  = cyc + LAT;
      e.rise = r;
      e.fall = f;
      sb.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      ed_rst = rst;
      @(negedge clk);
      exp_r = 4'h0;
      exp_f = 4'h0;
      if (ed_rst) begin
         sb.delete();
         exp_db = 4'h0;
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
         ev_t e;
         e      = sb.pop_front();
         exp_r  = e.rise;
         exp_f  = e.fall;
         exp_db = (exp_db | e.rise) & ~e.fall;
      end
      chk("db", db, exp_db);
      chk("rise", rise, exp_r);
      chk("fall", fall, exp_f);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      // Reset with all inputs high.
      rst = 1'b1;
      btn = 4'hF;
      ticks(3);
      rst = 1'b0;
      push(4'hF, 4'h0);
      ticks(12);
      btn = 4'h0;
      push(4'h0, 4'hF);
      ticks(12);

      // Clean press and release on ch0.
      btn[0] = 1'b1;
      push(4'h1, 4'h0);
      ticks(12);
      btn[0] = 1'b0;
      push(4'h0, 4'h1);
      ticks(12);

      // Bounce on ch1 never accepted.
      btn[1] = 1'b1;
      ticks(5);
      btn[1] = 1'b0;
      ticks(1);
      btn[1] = 1'b1;
      ticks(5);
      btn[1] = 1'b0;
      ticks(12);

      // Bounce then settle on ch2.
      for (int g = 0; g < 3; g++) begin
         btn[2] = 1'b1;
         ticks(2);
         btn[2] = 1'b0;
         ticks(2);
      end
      btn[2] = 1'b1;
      push(4'h4, 4'h0);
      ticks(12);
      btn[2] = 1'b0;
      push(4'h0, 4'h4);
      ticks(12);

      // Independence: ch0+ch3 together, ch1 three cycles later.
      btn = 4'b1001;
      push(4'b1001, 4'h0);
      ticks(3);
      btn[1] = 1'b1;
      push(4'b0010, 4'h0);
      ticks(12);
      btn = 4'h0;
      push(4'h0, 4'b1011);
      ticks(12);

      // Mid-count reset restarts full latency.
      btn[0] = 1'b1;
      push(4'h1, 4'h0);
      ticks(6);
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      push(4'h1, 4'h0);
      ticks(12);
      btn[0] = 1'b0;
      push(4'h0, 4'h1);
      ticks(12);

      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL sb_empty observed=%0d expected=0", sb.size());
      end

      // STABLE_CYCLES=1: no filtering, one edge after s.
      chk("db1_rst", db1, 4'h0);
      rst1 = 1'b0;
      ticks(2);
      btn1 = 4'h1;
      ticks(2);
      chk("db1_pre", db1, 4'h0);
      tick();
      chk("db1_acc", db1, 4'h1);
      chk("rise1_acc", rise1, 4'h1);
      tick();
      chk("rise1_end", rise1, 4'h0);
      btn1[1] = 1'b1;
      tick();
      btn1[1] = 1'b0;
      tick();
      chk("db1_gl0", db1, 4'h1);
      tick();
      chk("db1_gl1", db1, 4'h3);
      chk("rise1_gl", rise1, 4'h2);
      tick();
      chk("db1_gl2", db1, 4'h1);
      chk("fall1_gl", fall1, 4'h2);
      chk("rise1_gl2", rise1, 4'h0);
      rst1 = 1'b1;
      tick();
      chk("db1_rst2", db1, 4'h0);
      chk("fall1_rst", fall1, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
